// File: rtl/div_strobe_monitor.sv
// Strobe-period monitor: measures the interval between strobes, locks after LOCK_CNT
// good intervals of DIV cycles, and flags early/late strobes. Option: DIV_STROBE_MONITOR_STICKY_ERR_EN.
module div_strobe_monitor #(
    parameter int DIV      = 3,
    parameter int LOCK_CNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       strobe,
    output logic       locked,
    output logic       err,
    output logic [7:0] period,
    output logic       period_valid,
    output logic [7:0] err_count,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACQ    = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] DIV_C  = 8'(DIV);
    localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);

    state_t     state_q, state_d;
    logic [3:0] good_q, good_d;
    logic       late_q, late_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] period_q, period_d;
    logic       pv_q, pv_d;
    logic       err_q, err_d;
    logic [7:0] err_count_q, err_count_d;
    logic       err_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            good_q      <= 4'd0;
            late_q      <= 1'b0;
            cnt_q       <= 8'd0;
            period_q    <= 8'd0;
            pv_q        <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            good_q      <= good_d;
            late_q      <= late_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            pv_q        <= pv_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    // late_q marks an interval already reported as late, so its closing strobe is not an error.
    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        late_d   = late_q;
        err_flag = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    state_d = S_ACQ;
                    good_d  = 4'd0;
                    late_d  = 1'b0;
                end
            end
            S_ACQ, S_LOCKED: begin
                if (strobe) begin
                    late_d = 1'b0;
                    if (late_q) begin
                        good_d = 4'd0;
                    end else if (cnt_q == DIV_C) begin
                        if (state_q == S_ACQ) begin
                            good_d = good_q + 4'd1;
                            if (good_d == LOCK_C) state_d = S_LOCKED;
                        end
                    end else begin
                        err_flag = 1'b1;
                        good_d   = 4'd0;
                        state_d  = S_ACQ;
                    end
                end else if (cnt_q == DIV_C && !late_q) begin
                    err_flag = 1'b1;
                    late_d   = 1'b1;
                    good_d   = 4'd0;
                    state_d  = S_ACQ;
                end
            end
            default: begin
                state_d = S_IDLE;
                good_d  = 4'd0;
                late_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        cnt_d       = strobe ? 8'd1 : ((cnt_q == 8'd255) ? 8'd255 : cnt_q + 8'd1);
        pv_d        = strobe && (state_q != S_IDLE);
        period_d    = pv_d ? cnt_q : period_q;
        err_count_d = (err_flag && err_count_q != 8'd255) ? err_count_q + 8'd1 : err_count_q;
`ifdef DIV_STROBE_MONITOR_STICKY_ERR_EN
        err_d       = err_q | err_flag;
`else
        err_d       = err_flag;
`endif
    end

    always_comb begin
        locked       = (state_q == S_LOCKED);
        state_o      = state_q;
        err          = err_q;
        period       = period_q;
        period_valid = pv_q;
        err_count    = err_count_q;
    end

endmodule

// File: tb/tb_div_strobe_monitor.sv
// Directed bench for div_strobe_monitor (DIV=3, LOCK_CNT=4): vector table plus
// hand sequences for late strobes, stuck-high strobe, reset mid-lock and sticky err.
module tb_div_strobe_monitor;

    logic       clk;
    logic       reset;
    logic       strobe;
    logic       locked;
    logic       err;
    logic [7:0] period;
    logic       period_valid;
    logic [7:0] err_count;
    logic [1:0] state_o;

`ifdef DIV_STROBE_MONITOR_STICKY_ERR_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    div_strobe_monitor #(.DIV(3), .LOCK_CNT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .strobe       (strobe),
        .locked       (locked),
        .err          (err),
        .period       (period),
        .period_valid (period_valid),
        .err_count    (err_count),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       stb;
        logic       ex_locked;
        logic       ex_err;
        logic [7:0] ex_period;
        logic       ex_pv;
        logic [7:0] ex_ec;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic s, logic lk, logic e, logic [7:0] p,
                                logic pv, logic [7:0] ec);
        vec_t v;
        v.rst = r; v.stb = s; v.ex_locked = lk; v.ex_err = e;
        v.ex_period = p; v.ex_pv = pv; v.ex_ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: inputs applied now, outputs sampled 1 time unit after the edge.
    task automatic step(input logic r, input logic s);
        reset  = r;
        strobe = s;
        @(posedge clk);
        #1;
    endtask

    task automatic lock_up();
        step(1'b0, 1'b1);
        repeat (4) begin
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b1);
        end
    endtask

    task automatic early();
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
    endtask

    task automatic relock();
        repeat (4) begin
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b1);
        end
    endtask

    int err_hi;
    int pv_hi;

    initial begin
        reset  = 1'b1;
        strobe = 1'b0;

        // reset, strobes at cycles 0,3,6,9,12 (lock), then early strobe at 14
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 3, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 3, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 3, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 3, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 3, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 2, 1, 1));
        vecs.push_back(mk(0, 0, 0, STICKY, 2, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].stb);
            chk($sformatf("v%0d.locked", i), 32'(locked), 32'(vecs[i].ex_locked));
            chk($sformatf("v%0d.err", i), 32'(err), 32'(vecs[i].ex_err));
            chk($sformatf("v%0d.period", i), 32'(period), 32'(vecs[i].ex_period));
            chk($sformatf("v%0d.pv", i), 32'(period_valid), 32'(vecs[i].ex_pv));
            chk($sformatf("v%0d.err_count", i), 32'(err_count), 32'(vecs[i].ex_ec));
        end

        // late strobe: missing at interval 3, arrives at interval 5
        step(1'b1, 1'b0);
        lock_up();
        chk("late.locked_before", 32'(locked), 32'd1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("late.no_err_yet", 32'(err), 32'd0);
        step(1'b0, 1'b0);
        chk("late.err", 32'(err), 32'd1);
        chk("late.locked_drop", 32'(locked), 32'd0);
        chk("late.ec", 32'(err_count), 32'd1);
        step(1'b0, 1'b0);
        chk("late.err_after", 32'(err), 32'(STICKY));
        step(1'b0, 1'b1);
        chk("late.period", 32'(period), 32'd5);
        chk("late.pv", 32'(period_valid), 32'd1);
        chk("late.no_second_err", 32'(err_count), 32'd1);
        chk("late.err_on_strobe", 32'(err), 32'(STICKY));

        // strobe stuck high for 300 cycles
        step(1'b1, 1'b0);
        err_hi = 0;
        pv_hi  = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1);
            if (err) err_hi++;
            if (period_valid) pv_hi++;
            if (locked) err_hi += 1000;
        end
        chk("stuck.err_cycles", 32'(err_hi), 32'd299);
        chk("stuck.pv_cycles", 32'(pv_hi), 32'd299);
        chk("stuck.period", 32'(period), 32'd1);
        chk("stuck.ec_sat", 32'(err_count), 32'd255);
        chk("stuck.locked", 32'(locked), 32'd0);

        // two early errors with relocks, then reset while locked
        step(1'b1, 1'b0);
        lock_up();
        early();
        chk("early.err", 32'(err), 32'd1);
        chk("early.period", 32'(period), 32'd2);
        relock();
        chk("relock.locked", 32'(locked), 32'd1);
        chk("relock.err", 32'(err), 32'(STICKY));
        early();
        relock();
        chk("relock2.locked", 32'(locked), 32'd1);
        chk("relock2.ec", 32'(err_count), 32'd2);
        chk("relock2.err", 32'(err), 32'(STICKY));
        step(1'b1, 1'b0);
        chk("rst.locked", 32'(locked), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.period", 32'(period), 32'd0);
        chk("rst.pv", 32'(period_valid), 32'd0);
        chk("rst.ec", 32'(err_count), 32'd0);
        chk("rst.state", 32'(state_o), 32'd0);
        step(1'b0, 1'b1);
        chk("post_rst.pv", 32'(period_valid), 32'd0);
        chk("post_rst.state", 32'(state_o), 32'd1);
        chk("post_rst.period", 32'(period), 32'd0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("post_rst.meas_pv", 32'(period_valid), 32'd1);
        chk("post_rst.meas", 32'(period), 32'd3);
        chk("post_rst.err", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_strobe_monitor.md
DIV_STROBE_MONITOR -- requirements
Module: div_strobe_monitor

Interface
REQ-001 SHALL have parameter DIV, default 3, meaning the expected strobe period in clk cycles (legal range 2..254).
REQ-002 SHALL have parameter LOCK_CNT, default 4, meaning the number of consecutive good intervals needed to lock (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port strobe, input, 1 bit, the divided pulse under test (high one cycle per period), synchronous to clk.
REQ-006 SHALL have port locked, output, 1 bit, high while in LOCKED.
REQ-007 SHALL have port err, output, 1 bit, error indication.
REQ-008 SHALL have port period, output, 8 bits, the last measured strobe interval.
REQ-009 SHALL have port period_valid, output, 1 bit, a one-cycle pulse when period updates.
REQ-010 SHALL have port err_count, output, 8 bits, a saturating count of errors.

Function
REQ-011 SHALL keep an interval counter cnt: set to 1 on a strobe cycle, otherwise +1, saturating at 255.
REQ-012 SHALL define the measured interval at a strobe as the cnt value before update; strobes at cycles t and t+N measure N.
REQ-013 SHALL implement states IDLE (no strobe since reset), ACQ and LOCKED, with a good-interval counter good (4 bits).
REQ-014 IDLE: on strobe, SHALL go to ACQ with good=0; no measurement, no period_valid.
REQ-015 ACQ/LOCKED: on each strobe, SHALL register period=measured and pulse period_valid in the next cycle.
REQ-016 ACQ: if measured==DIV, SHALL increment good; when it reaches LOCK_CNT, SHALL go to LOCKED.
REQ-017 ACQ: if measured!=DIV, SHALL clear good and flag an error (early or late).
REQ-018 SHALL detect a late strobe: a cycle with cnt==DIV and strobe low in ACQ/LOCKED flags an error, clears good and goes to (or stays in) ACQ.
REQ-019 After a late detection, the next strobe SHALL update period but SHALL NOT flag a second error for the same interval.
REQ-020 LOCKED: measured==DIV SHALL stay LOCKED; measured!=DIV SHALL flag an error, clear good and go to ACQ.
REQ-021 A strobe in the same cycle that cnt==DIV SHALL count as good, not late.
REQ-022 locked SHALL be a Moore output (state==LOCKED) and SHALL change one cycle after the deciding strobe.
REQ-023 err SHALL be registered and asserted in the cycle after an error is flagged.
REQ-024 err_count SHALL increment once per flagged error and saturate at 255.

Reset
REQ-025 With reset high at a clk edge: state=IDLE, good=0, cnt=0, locked=0, err=0, period=0, period_valid=0, err_count=0.
REQ-026 Reset mid-operation SHALL discard all history; the first strobe after reset SHALL produce no measurement.

Configuration
REQ-027 Macro DIV_STROBE_MONITOR_STICKY_ERR_EN defined: err SHALL latch high on the first error and hold until reset.
REQ-028 Macro undefined: err SHALL be a one-cycle pulse per flagged error.
REQ-029 err_count and the state transitions SHALL be identical with or without the macro.

Verification (DIV=3, LOCK_CNT=4, macro undefined unless stated)
REQ-030 Reset, then strobes at cycles 0,3,6,9,12 -> locked=1 from cycle 13; period=3 each; err never high; err_count=0.
REQ-031 Locked, next strobe 2 cycles after the previous -> period=2, err pulses one cycle, locked=0 next cycle, err_count=1.
REQ-032 Locked, strobe missing, then arrives at interval 5 -> err pulses once (late at cnt==3), locked drops; period=5 with no second err; err_count=1.
REQ-033 strobe held high for 300 cycles after IDLE exit -> period=1 repeatedly, err every cycle, err_count saturates at 255, locked stays 0.
REQ-034 Reset asserted while locked with err_count=2 -> next cycle all outputs 0, state IDLE; the next single strobe gives no period_valid.
REQ-035 Macro defined, REQ-031 stimulus -> err rises and stays 1 through later good strobes and relock until reset.
